mult_div_unit: RTL and testbench

//  Multi-cycle MULT/MULTU/DIV/DIVU unit with HI/LO registers. Sits beside the ALU in the execute

---
 rtl/mult_div_unit_pkg.sv | 43 ++++
 rtl/mdu_divider_core.sv | 64 ++++++
 rtl/mult_div_unit.sv | 148 ++++++++++++++
 tb/tb_mult_div_unit.sv | 207 ++++++++++++++++++++
 4 files changed

// File: rtl/mult_div_unit_pkg.sv
// Shared definitions for the multiply/divide unit: op encodings, FSM states, op decode helpers.
// The control unit imports the same package so both sides agree on the op field.
package mult_div_unit_pkg;

    typedef enum logic [2:0] {
        MDU_NOP   = 3'b000,
        MDU_MULT  = 3'b001,
        MDU_MULTU = 3'b010,
        MDU_DIV   = 3'b011,
        MDU_DIVU  = 3'b100,
        MDU_MTHI  = 3'b101,
        MDU_MTLO  = 3'b110,
        MDU_NOP7  = 3'b111
    } mdu_op_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_CALC = 2'b01,
        ST_FIX  = 2'b10
    } mdu_state_e;

    function automatic logic mdu_is_iter(input logic [2:0] op);
        case (op)
            MDU_MULT, MDU_MULTU, MDU_DIV, MDU_DIVU: return 1'b1;
            default:                                return 1'b0;
        endcase
    endfunction

    function automatic logic mdu_is_signed(input logic [2:0] op);
        case (op)
            MDU_MULT, MDU_DIV: return 1'b1;
            default:           return 1'b0;
        endcase
    endfunction

    function automatic logic mdu_is_mul(input logic [2:0] op);
        case (op)
            MDU_MULT, MDU_MULTU: return 1'b1;
            default:             return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/mdu_divider_core.sv
// Unsigned restoring divider: one quotient bit per step, plus the shared iteration counter.
// The quotient register starts as the dividend and shifts quotient bits in from the right.
module mdu_divider_core #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic             step,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             last
);

    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] CNT_ONE = {{(CW-1){1'b0}}, 1'b1};

    logic [WIDTH-1:0] quot_r;
    logic [WIDTH-1:0] rem_r;
    logic [WIDTH-1:0] div_r;
    logic [CW-1:0]    count_r;
    logic [WIDTH:0]   shifted_s;
    logic             ge_s;
    logic [WIDTH-1:0] rem_next_s;

    // Trial subtraction on the WIDTH+1 bit partial remainder.
    always_comb begin
        shifted_s = {rem_r, quot_r[WIDTH-1]};
        ge_s      = (shifted_s >= {1'b0, div_r});
        if (ge_s) begin
            rem_next_s = shifted_s[WIDTH-1:0] - div_r;
        end else begin
            rem_next_s = shifted_s[WIDTH-1:0];
        end
    end

    // Divide step registers and iteration counter.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            quot_r  <= {WIDTH{1'b0}};
            rem_r   <= {WIDTH{1'b0}};
            div_r   <= {WIDTH{1'b0}};
            count_r <= {CW{1'b0}};
        end else if (load) begin
            quot_r  <= dividend;
            rem_r   <= {WIDTH{1'b0}};
            div_r   <= divisor;
            count_r <= CW'(WIDTH - 1);
        end else if (step) begin
            quot_r <= {quot_r[WIDTH-2:0], ge_s};
            rem_r  <= rem_next_s;
            if (count_r != {CW{1'b0}}) begin
                count_r <= count_r - CNT_ONE;
            end
        end
    end

    assign quotient  = quot_r;
    assign remainder = rem_r;
    assign last      = (count_r == {CW{1'b0}});

endmodule

// File: rtl/mult_div_unit.sv
// Multi-cycle MULT/MULTU/DIV/DIVU unit with HI/LO registers for the execute stage.
// Multiply and sign fix-up live here; magnitudes go through WIDTH iterations then one FIX cycle.
module mult_div_unit
    import mult_div_unit_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] srca,
    input  logic [WIDTH-1:0] srcb,
    output logic             busy,
    output logic             done,
    output logic             stall,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    mdu_state_e         state_r, state_nxt_s;
    logic               busy_r, done_r;
    logic [WIDTH-1:0]   hi_r, lo_r;
    logic               is_mul_r, neg_lo_r, neg_hi_r, div_zero_r;
    logic [WIDTH-1:0]   a_raw_r, mcand_r;
    logic [2*WIDTH-1:0] prod_r;

    logic               accept_s, iter_go_s, a_neg_s, b_neg_s, last_s;
    logic [WIDTH-1:0]   a_mag_s, b_mag_s, quot_s, rem_s;
    logic [WIDTH:0]     mul_sum_s;
    logic [2*WIDTH-1:0] prod_fix_s;
    logic [WIDTH-1:0]   hi_fix_s, lo_fix_s;

    assign accept_s  = start & ~busy_r;
    assign iter_go_s = accept_s & mdu_is_iter(op);
    assign a_neg_s   = mdu_is_signed(op) & srca[WIDTH-1];
    assign b_neg_s   = mdu_is_signed(op) & srcb[WIDTH-1];
    // The most negative value negates to itself, which is its correct unsigned magnitude.
    assign a_mag_s   = a_neg_s ? -srca : srca;
    assign b_mag_s   = b_neg_s ? -srcb : srcb;

    mdu_divider_core #(.WIDTH(WIDTH)) u_div (
        .clk       (clk),
        .reset     (reset),
        .load      (iter_go_s),
        .step      (state_r == ST_CALC),
        .dividend  (a_mag_s),
        .divisor   (b_mag_s),
        .quotient  (quot_s),
        .remainder (rem_s),
        .last      (last_s)
    );

    // FSM next state.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            ST_IDLE: if (iter_go_s) state_nxt_s = ST_CALC; else state_nxt_s = ST_IDLE;
            ST_CALC: if (last_s)    state_nxt_s = ST_FIX;  else state_nxt_s = ST_CALC;
            ST_FIX:  state_nxt_s = ST_IDLE;
            default: state_nxt_s = ST_IDLE;
        endcase
    end

    // FSM state and registered status flags.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r <= ST_IDLE;
            busy_r  <= 1'b0;
            done_r  <= 1'b0;
        end else begin
            state_r <= state_nxt_s;
            busy_r  <= (state_nxt_s != ST_IDLE);
            done_r  <= (state_r == ST_FIX);
        end
    end

    // One shift-add step: conditionally add the multiplicand into the upper half.
    always_comb begin
        if (prod_r[0]) begin
            mul_sum_s = {1'b0, prod_r[2*WIDTH-1:WIDTH]} + {1'b0, mcand_r};
        end else begin
            mul_sum_s = {1'b0, prod_r[2*WIDTH-1:WIDTH]};
        end
    end

    // Operand capture at accept and multiply product register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            is_mul_r   <= 1'b0;
            neg_lo_r   <= 1'b0;
            neg_hi_r   <= 1'b0;
            div_zero_r <= 1'b0;
            a_raw_r    <= {WIDTH{1'b0}};
            mcand_r    <= {WIDTH{1'b0}};
            prod_r     <= {(2*WIDTH){1'b0}};
        end else if (iter_go_s) begin
            is_mul_r   <= mdu_is_mul(op);
            neg_lo_r   <= a_neg_s ^ b_neg_s;
            neg_hi_r   <= a_neg_s & ~mdu_is_mul(op);
            div_zero_r <= (srcb == {WIDTH{1'b0}}) & ~mdu_is_mul(op);
            a_raw_r    <= srca;
            mcand_r    <= a_mag_s;
            prod_r     <= {{WIDTH{1'b0}}, b_mag_s};
        end else if (state_r == ST_CALC) begin
            prod_r <= {mul_sum_s, prod_r[WIDTH-1:1]};
        end
    end

    // Sign fix-up applied in FIX; divide-by-zero bypasses it entirely.
    always_comb begin
        prod_fix_s = neg_lo_r ? -prod_r : prod_r;
        if (is_mul_r) begin
            hi_fix_s = prod_fix_s[2*WIDTH-1:WIDTH];
            lo_fix_s = prod_fix_s[WIDTH-1:0];
        end else if (div_zero_r) begin
            hi_fix_s = a_raw_r;
            lo_fix_s = {WIDTH{1'b1}};
        end else begin
            hi_fix_s = neg_hi_r ? -rem_s : rem_s;
            lo_fix_s = neg_lo_r ? -quot_s : quot_s;
        end
    end

    // HI/LO: written by MTHI/MTLO at accept or by iterative ops leaving FIX.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            hi_r <= {WIDTH{1'b0}};
            lo_r <= {WIDTH{1'b0}};
        end else if (state_r == ST_FIX) begin
            hi_r <= hi_fix_s;
            lo_r <= lo_fix_s;
        end else if (accept_s) begin
            case (op)
                MDU_MTHI: hi_r <= srca;
                MDU_MTLO: lo_r <= srca;
                default:  begin end
            endcase
        end
    end

    assign busy  = busy_r;
    assign done  = done_r;
    assign stall = busy_r & start;
    assign hi    = hi_r;
    assign lo    = lo_r;

endmodule

// File: tb/tb_mult_div_unit.sv
// Self-checking bench for mult_div_unit: directed cases plus random ops against an arithmetic model.
module tb_mult_div_unit;

    localparam int W = 32;

    logic         clk;
    logic         reset;
    logic         start;
    logic [2:0]   op;
    logic [W-1:0] srca, srcb;
    logic         busy, done, stall;
    logic [W-1:0] hi, lo;

    int           total = 0;
    int           bad   = 0;
    logic [W-1:0] exp_hi = 32'h0;
    logic [W-1:0] exp_lo = 32'h0;

    mult_div_unit #(.WIDTH(W)) dut (
        .clk   (clk),
        .reset (reset),
        .start (start),
        .op    (op),
        .srca  (srca),
        .srcb  (srcb),
        .busy  (busy),
        .done  (done),
        .stall (stall),
        .hi    (hi),
        .lo    (lo)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        total++;
        assert (obs === expv) else begin
            bad++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, expv);
        end
    endtask

    // Architectural result of one command, straight from signed/unsigned arithmetic.
    task automatic model(input logic [2:0] o, input logic [W-1:0] a, input logic [W-1:0] b);
        longint      sp;
        logic [63:0] up;
        int          sa, sb;
        sa = $signed(a);
        sb = $signed(b);
        case (o)
            3'd1: begin
                sp = longint'(sa) * longint'(sb);
                up = 64'(sp);
                exp_hi = up[63:32];
                exp_lo = up[31:0];
            end
            3'd2: begin
                up = {32'h0, a} * {32'h0, b};
                exp_hi = up[63:32];
                exp_lo = up[31:0];
            end
            3'd3: begin
                if (b == 32'h0) begin
                    exp_hi = a; exp_lo = 32'hffff_ffff;
                end else if (a == 32'h8000_0000 && b == 32'hffff_ffff) begin
                    exp_hi = 32'h0; exp_lo = 32'h8000_0000;
                end else begin
                    exp_lo = 32'(sa / sb);
                    exp_hi = 32'(sa % sb);
                end
            end
            3'd4: begin
                if (b == 32'h0) begin
                    exp_hi = a; exp_lo = 32'hffff_ffff;
                end else begin
                    exp_lo = a / b;
                    exp_hi = a % b;
                end
            end
            3'd5: exp_hi = a;
            3'd6: exp_lo = a;
            default: begin end
        endcase
    endtask

    // Issue one command at the current negedge; returns at the negedge where the result is visible.
    task automatic do_op(input logic [2:0] o, input logic [W-1:0] a, input logic [W-1:0] b);
        logic [W-1:0] old_hi, old_lo;
        int           n;
        bit           iter;
        iter  = (o >= 3'd1) && (o <= 3'd4);
        start = 1'b1; op = o; srca = a; srcb = b;
        #1 chk("stall_idle", {63'h0, stall}, 64'h0);
        @(negedge clk);
        start = 1'b0;
        op    = 3'($urandom_range(0, 7));
        srca  = $urandom;
        srcb  = $urandom;
        old_hi = exp_hi;
        old_lo = exp_lo;
        model(o, a, b);
        chk("done_first", {63'h0, done}, 64'h0);
        if (iter) begin
            n = 0;
            while (busy === 1'b1 && n < 40) begin
                n++;
                chk("hold_hi", {32'h0, hi}, {32'h0, old_hi});
                chk("hold_lo", {32'h0, lo}, {32'h0, old_lo});
                @(negedge clk);
            end
            chk("busy_cycles", 64'(n), 64'd33);
            chk("done_pulse", {63'h0, done}, 64'h1);
        end
        chk("busy_after", {63'h0, busy}, 64'h0);
        chk("hi", {32'h0, hi}, {32'h0, exp_hi});
        chk("lo", {32'h0, lo}, {32'h0, exp_lo});
    endtask

    initial begin
        bit           seen;
        logic [2:0]   ro;
        logic [W-1:0] ra, rb;
        int           sel;

        reset = 1'b1; start = 1'b0; op = 3'd0; srca = 32'h0; srcb = 32'h0;
        repeat (2) @(negedge clk);
        chk("rst_busy", {63'h0, busy}, 64'h0);
        chk("rst_done", {63'h0, done}, 64'h0);
        chk("rst_hi", {32'h0, hi}, 64'h0);
        chk("rst_lo", {32'h0, lo}, 64'h0);
        reset = 1'b0;
        @(negedge clk);

        do_op(3'd2, 32'hffff_ffff, 32'hffff_ffff);
        chk("t1_hi", {32'h0, hi}, 64'hffff_fffe);
        chk("t1_lo", {32'h0, lo}, 64'h0000_0001);
        do_op(3'd1, 32'hffff_fffd, 32'd7);
        chk("t2_mult_hi", {32'h0, hi}, 64'hffff_ffff);
        chk("t2_mult_lo", {32'h0, lo}, 64'hffff_ffeb);
        do_op(3'd4, 32'd100, 32'd7);
        chk("t2_divu_hi", {32'h0, hi}, 64'd2);
        chk("t2_divu_lo", {32'h0, lo}, 64'd14);
        do_op(3'd3, 32'hffff_fff9, 32'd2);
        chk("t3_div_hi", {32'h0, hi}, 64'hffff_ffff);
        chk("t3_div_lo", {32'h0, lo}, 64'hffff_fffd);
        do_op(3'd3, 32'h8000_0000, 32'hffff_ffff);
        chk("t3_ovf_hi", {32'h0, hi}, 64'h0);
        chk("t3_ovf_lo", {32'h0, lo}, 64'h8000_0000);
        do_op(3'd3, 32'hffff_fffb, 32'h0);
        chk("t4_div0_hi", {32'h0, hi}, 64'hffff_fffb);
        chk("t4_div0_lo", {32'h0, lo}, 64'hffff_ffff);
        do_op(3'd4, 32'd5, 32'h0);
        chk("t4_divu0_hi", {32'h0, hi}, 64'd5);
        chk("t4_divu0_lo", {32'h0, lo}, 64'hffff_ffff);
        do_op(3'd5, 32'h1234_5678, 32'h0);
        chk("t5_mthi", {32'h0, hi}, 64'h1234_5678);
        do_op(3'd6, 32'h9abc_def0, 32'h0);
        chk("t5_mtlo_lo", {32'h0, lo}, 64'h9abc_def0);
        chk("t5_mtlo_hi", {32'h0, hi}, 64'h1234_5678);

        for (int i = 0; i < 24; i++) begin
            ro  = 3'($urandom_range(0, 7));
            sel = $urandom_range(0, 5);
            ra  = (sel == 5) ? 32'h8000_0000 : $urandom;
            rb  = (sel == 0) ? 32'h0 : (sel == 1) ? 32'($urandom_range(1, 15)) :
                  (sel == 2) ? 32'hffff_ffff : $urandom;
            do_op(ro, ra, rb);
        end

        do_op(3'd5, 32'hdead_beef, 32'h0);
        do_op(3'd6, 32'h0bad_cafe, 32'h0);
        start = 1'b1; op = 3'd3; srca = 32'h7fff_0001; srcb = 32'd3;
        @(negedge clk);
        start = 1'b0;
        repeat (4) @(negedge clk);
        start = 1'b1; op = 3'd1; srca = 32'd9; srcb = 32'd9;
        #1 chk("t6_stall", {63'h0, stall}, 64'h1);
        @(negedge clk);
        start = 1'b0;
        repeat (4) @(negedge clk);
        chk("t6_busy_pre", {63'h0, busy}, 64'h1);
        chk("t6_hold_hi", {32'h0, hi}, 64'hdead_beef);
        #2 reset = 1'b1;
        #1;
        chk("t6_rst_busy", {63'h0, busy}, 64'h0);
        chk("t6_rst_done", {63'h0, done}, 64'h0);
        chk("t6_rst_hi", {32'h0, hi}, 64'h0);
        chk("t6_rst_lo", {32'h0, lo}, 64'h0);
        exp_hi = 32'h0;
        exp_lo = 32'h0;
        @(negedge clk);
        reset = 1'b0;
        seen = 1'b0;
        for (int c = 0; c < 40; c++) begin
            if (done !== 1'b0 || busy !== 1'b0 || hi !== 32'h0 || lo !== 32'h0) seen = 1'b1;
            @(negedge clk);
        end
        chk("t6_quiet", {63'h0, seen}, 64'h0);

        do_op(3'd2, $urandom, $urandom);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
